// File: rtl/prbs_pkg.sv
// Shared types, default polynomials and the reference-prediction helper for the PRBS checker.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned PRED_MAX_W = 32;

    // Masks use the generator convention: polynomial representation >> 1.
    localparam logic [7:0] PRBS8_FB = 8'h8e;
    localparam logic [6:0] PRBS7_FB = 7'h60;

    function automatic logic prbs_pred(input logic [PRED_MAX_W-1:0] hist,
                                       input logic [PRED_MAX_W-1:0] fb);
        return ^(hist & fb);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over counting.
module sat_counter #(
    parameter int unsigned CW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises a local reference to a Galois LFSR bit stream,
// then counts checked bits and bit errors, dropping lock on excessive errors per window.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned    N        = 8,
    parameter logic [N-1:0]   FB       = PRBS8_FB,
    parameter int unsigned    LOCK_CNT = 16,
    parameter int unsigned    WIN      = 256,
    parameter int unsigned    ERR_TH   = 16,
    parameter int unsigned    CW       = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_in_bit,
    input  logic          i_clr,
    output logic          o_locked,
    output logic          o_err,
    output logic [CW-1:0] o_bit_cnt,
    output logic [CW-1:0] o_err_cnt
);

    localparam int unsigned FW = $clog2(N + 1);
    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(WIN);
    localparam int unsigned EW = $clog2(ERR_TH + 1);

    state_t        r_state;
    logic [N-1:0]  r_hist;
    logic [FW-1:0] r_fill_cnt;
    logic [MW-1:0] r_match_cnt;
    logic [WW-1:0] r_win_cnt;
    logic [EW-1:0] r_win_err;
    logic          r_locked;
    logic          r_err;

    logic          w_pred;
    logic          w_mism;
    logic          w_match;
    logic          w_count;
    logic [EW-1:0] w_win_err_nxt;

    assign w_pred        = prbs_pred(PRED_MAX_W'(r_hist), PRED_MAX_W'(FB));
    assign w_mism        = i_in_bit ^ w_pred;
    assign w_match       = !w_mism && (r_hist != '0);
    assign w_count       = i_en && (r_state == LOCKED);
    assign w_win_err_nxt = r_win_err + EW'(w_mism);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= SEARCH;
            r_hist      <= '0;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (i_en) begin
                case (r_state)
                    SEARCH: begin
                        r_hist <= {r_hist[N-2:0], i_in_bit};
                        if (r_fill_cnt < FW'(N)) begin
                            r_fill_cnt <= r_fill_cnt + FW'(1);
                        end else if (w_match) begin
                            r_match_cnt <= r_match_cnt + MW'(1);
                            if (r_match_cnt == MW'(LOCK_CNT - 1)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running reference so a received error is not fed back.
                        r_hist <= {r_hist[N-2:0], w_pred};
                        r_err  <= w_mism;
                        if (w_mism && (w_win_err_nxt == EW'(ERR_TH))) begin
                            r_state     <= SEARCH;
                            r_locked    <= 1'b0;
                            r_fill_cnt  <= '0;
                            r_match_cnt <= '0;
                            r_win_cnt   <= '0;
                            r_win_err   <= '0;
                        end else if (r_win_cnt == WW'(WIN - 1)) begin
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WW'(1);
                            r_win_err <= w_win_err_nxt;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    sat_counter #(.CW(CW)) u_bit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_en  (w_count),
        .i_inc (1'b1),
        .o_cnt (o_bit_cnt)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_en  (w_count),
        .i_inc (w_mism),
        .o_cnt (o_err_cnt)
    );

    assign o_locked = r_locked;
    assign o_err    = r_err;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: Galois generator stimulus, per-cycle expectations
// checked by a decoupled monitor against a 32-bit and a 4-bit counter instance.
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam logic [7:0] GEN_FB   = 8'h8e;
    localparam logic [7:0] GEN_INIT = 8'hff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err, locked4, err4;
    logic [31:0] bit_cnt, err_cnt;
    logic [3:0]  bit_cnt4, err_cnt4;

    always #5 clk = ~clk;

    prbs_checker #(.N(8), .FB(8'h8e), .LOCK_CNT(16), .WIN(256), .ERR_TH(16), .CW(32)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in_bit(in_bit), .i_clr(clr),
        .o_locked(locked), .o_err(err), .o_bit_cnt(bit_cnt), .o_err_cnt(err_cnt)
    );

    prbs_checker #(.N(8), .FB(8'h8e), .LOCK_CNT(16), .WIN(256), .ERR_TH(16), .CW(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in_bit(in_bit), .i_clr(clr),
        .o_locked(locked4), .o_err(err4), .o_bit_cnt(bit_cnt4), .o_err_cnt(err_cnt4)
    );

    typedef struct {
        int   cyc;
        logic lk;
        logic er;
        int   bc;
        int   ec;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    logic [7:0] gen;
    logic       e_lock, e_err, zero_mode;
    int         e_bit, e_errc, acq;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string nm, input int c, input longint got, input longint want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, c, got, want);
        end
    endtask

    // Monitor: compares every expectation whose cycle tag has been reached.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            x = sb.pop_front();
            chk("locked",   x.cyc, longint'(locked),   longint'(x.lk));
            chk("err",      x.cyc, longint'(err),      longint'(x.er));
            chk("bit_cnt",  x.cyc, longint'(bit_cnt),  longint'(x.bc));
            chk("err_cnt",  x.cyc, longint'(err_cnt),  longint'(x.ec));
            chk("locked4",  x.cyc, longint'(locked4),  longint'(x.lk));
            chk("bit_cnt4", x.cyc, longint'(bit_cnt4), longint'(sat4(x.bc)));
            chk("err_cnt4", x.cyc, longint'(err_cnt4), longint'(sat4(x.ec)));
        end
    end

    task automatic push();
        exp_t x;
        x.cyc = cyc;
        x.lk  = e_lock;
        x.er  = e_err;
        x.bc  = e_bit;
        x.ec  = e_errc;
        sb.push_back(x);
    endtask

    task automatic do_reset(input logic e);
        @(negedge clk);
        rst = 1'b1; en = e; in_bit = 1'b1; clr = 1'b0;
        @(posedge clk); #1;
        e_lock = 1'b0; e_err = 1'b0; e_bit = 0; e_errc = 0; acq = 0;
        gen = GEN_INIT;
        push();
    endtask

    // One clock of stimulus; lock is expected 24 clean valid bits after (re)start.
    task automatic send(input logic e, input logic flip, input logic c, input logic unlock);
        logic b;
        @(negedge clk);
        b = 1'b1;
        if (e) begin
            b   = gen[0];
            gen = (gen >> 1) ^ (b ? GEN_FB : 8'h00);
            if (zero_mode) b = 1'b0;
            b = b ^ flip;
        end
        rst = 1'b0; en = e; in_bit = b; clr = c;
        @(posedge clk); #1;
        e_err = 1'b0;
        if (c) begin
            e_bit = 0; e_errc = 0;
        end
        if (e) begin
            if (e_lock) begin
                e_err = flip;
                if (!c) begin
                    e_bit++;
                    e_errc += int'(flip);
                end
                if (unlock) begin
                    e_lock = 1'b0;
                    acq = 0;
                end
            end else begin
                acq++;
                if (acq == 24 && !zero_mode) e_lock = 1'b1;
            end
        end
        push();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        zero_mode = 1'b0;
        gen = GEN_INIT;
        do_reset(1'b0);
        do_reset(1'b1);

        // Acquisition, then 100 clean locked bits.
        for (int i = 0; i < 24; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) send(1'b1, 1'b0, 1'b0, 1'b0);

        // Single error, then fill out the first window (256 locked bits).
        for (int i = 0; i < 50; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 105; i++) send(1'b1, 1'b0, 1'b0, 1'b0);

        // Burst of 16 errors in the second window, then relock.
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send(1'b1, 1'b1, 1'b0, (i == 15));
        for (int i = 0; i < 24; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0, 1'b0);

        // All-zero input never locks.
        do_reset(1'b0);
        zero_mode = 1'b1;
        for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        zero_mode = 1'b0;

        // Gapped valid: lock after 24 valid bits, one error while gapped.
        do_reset(1'b0);
        for (int i = 0; i < 24; i++) begin
            send(1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            send(1'b1, (i == 4), 1'b0, 1'b0);
            send(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // clr wins over a counted bit, counting resumes afterwards.
        send(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0);

        // Reset while locked with valid data present.
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
